// File: rtl/shift_ex_pkg.sv
// rtl/shift_ex_pkg.sv - funct codes, FIFO entry layout and decode helpers for shift_ex
package shift_ex_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  localparam int ENTRY_W = 39;

  typedef struct packed {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        wreg;
    logic        illegal;
  } entry_t;

  typedef struct packed {
    logic [4:0] sa;
    logic       right;
    logic       arith;
    logic       illegal;
  } shift_ctl_t;

  // Non-shift functs leave sa=0 and right=0 so the shifter passes rt through untouched.
  function automatic shift_ctl_t decode_funct(input logic [5:0] funct,
                                              input logic [4:0] shamt,
                                              input logic [4:0] rs_sa);
    shift_ctl_t c;
    c = '0;
    case (funct)
      FUNCT_SLL:  c.sa = shamt;
      FUNCT_SRL:  begin c.sa = shamt; c.right = 1'b1; end
      FUNCT_SRA:  begin c.sa = shamt; c.right = 1'b1; c.arith = 1'b1; end
      FUNCT_SLLV: c.sa = rs_sa;
      FUNCT_SRLV: begin c.sa = rs_sa; c.right = 1'b1; end
      FUNCT_SRAV: begin c.sa = rs_sa; c.right = 1'b1; c.arith = 1'b1; end
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  function automatic logic [31:0] bit_reverse32(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[i] = d[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_mux.sv
// rtl/shift_mux.sv - 32-bit combinational barrel shifter, left/right logical and arithmetic
module shift_mux
  import shift_ex_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [4:0]  i_sa,
  input  logic        i_right,
  input  logic        i_arith,
  output logic [31:0] o_data
);

  logic [31:0] w_in;
  logic [31:0] w_s0;
  logic [31:0] w_s1;
  logic [31:0] w_s2;
  logic [31:0] w_s3;
  logic [31:0] w_s4;
  logic        w_fill;

  // Left shifts reuse the right-shift network on a bit-reversed operand.
  assign w_in   = i_right ? i_data : bit_reverse32(i_data);
  assign w_fill = i_right & i_arith & i_data[31];

  assign w_s0 = i_sa[0] ? {w_fill, w_in[31:1]}          : w_in;
  assign w_s1 = i_sa[1] ? {{2{w_fill}},  w_s0[31:2]}    : w_s0;
  assign w_s2 = i_sa[2] ? {{4{w_fill}},  w_s1[31:4]}    : w_s1;
  assign w_s3 = i_sa[3] ? {{8{w_fill}},  w_s2[31:8]}    : w_s2;
  assign w_s4 = i_sa[4] ? {{16{w_fill}}, w_s3[31:16]}   : w_s3;

  assign o_data = i_right ? w_s4 : bit_reverse32(w_s4);

endmodule

// File: rtl/shift_ex.sv
// rtl/shift_ex.sv - execute-stage shift unit: funct decode, barrel shift, tagged result FIFO
module shift_ex
  import shift_ex_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rd,
  output logic        out_wreg,
  output logic        out_illegal
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  shift_ctl_t       w_ctl;
  logic [31:0]      w_shifted;
  entry_t           w_entry;
  entry_t           w_head;
  logic             w_push;
  logic             w_pop;
  logic             w_unused_rs;

  entry_t           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  assign w_ctl       = decode_funct(in_funct, in_shamt, in_rs[4:0]);
  assign w_unused_rs = ^in_rs[31:5];

  shift_mux u_shift_mux (
    .i_data  (in_rt),
    .i_sa    (w_ctl.sa),
    .i_right (w_ctl.right),
    .i_arith (w_ctl.arith),
    .o_data  (w_shifted)
  );

  always_comb begin
    w_entry         = '0;
    w_entry.result  = w_shifted;
    w_entry.rd      = in_rd;
    w_entry.wreg    = ~w_ctl.illegal & (in_rd != 5'd0);
    w_entry.illegal = w_ctl.illegal;
  end

  // Both flags come from the occupancy register only, so neither side sees the other combinationally.
  assign in_ready  = (r_count != FULL_CNT);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head = r_mem[r_rd_ptr];

  // Storage is never cleared, so the head is masked while the FIFO is empty.
  assign out_result  = out_valid ? w_head.result  : 32'd0;
  assign out_rd      = out_valid ? w_head.rd      : 5'd0;
  assign out_wreg    = out_valid & w_head.wreg;
  assign out_illegal = out_valid & w_head.illegal;

endmodule

// File: tb/tb_shift_ex.sv
// tb/tb_shift_ex.sv - self-checking bench for shift_ex with a shift-operator reference model
module tb_shift_ex;

  localparam int DEPTH = 2;

  logic        clk;
  logic        clrn;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs;
  logic [31:0] in_rt;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rd;
  logic        out_wreg;
  logic        out_illegal;

  int n_checks;
  int n_fail;
  logic [38:0] exp_q[$];

  shift_ex #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_shamt    (in_shamt),
    .in_rs       (in_rs),
    .in_rt       (in_rt),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_rd      (out_rd),
    .out_wreg    (out_wreg),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [38:0] model_entry(input logic [5:0] f, input logic [4:0] shamt,
                                              input logic [31:0] rs, input logic [31:0] rt,
                                              input logic [4:0] rd);
    logic [31:0] res;
    logic        ill;
    ill = 1'b0;
    case (f)
      6'd0:    res = rt << shamt;
      6'd2:    res = rt >> shamt;
      6'd3:    res = 32'($signed(rt) >>> shamt);
      6'd4:    res = rt << rs[4:0];
      6'd6:    res = rt >> rs[4:0];
      6'd7:    res = 32'($signed(rt) >>> rs[4:0]);
      default: begin res = rt; ill = 1'b1; end
    endcase
    return {res, rd, (!ill && rd != 5'd0), ill};
  endfunction

  function automatic logic [38:0] observed();
    return {out_result, out_rd, out_wreg, out_illegal};
  endfunction

  task automatic rand_op(input bit legal_only);
    int p;
    p = $urandom_range(0, 7);
    if (legal_only) p = p % 6;
    case (p)
      0: in_funct = 6'd0;
      1: in_funct = 6'd2;
      2: in_funct = 6'd3;
      3: in_funct = 6'd4;
      4: in_funct = 6'd6;
      5: in_funct = 6'd7;
      default: in_funct = 6'($urandom);
    endcase
    in_shamt = 5'($urandom);
    in_rs    = $urandom;
    in_rt    = $urandom;
    in_rd    = 5'($urandom);
  endtask

  // Advance one clock, updating the scoreboard with whatever handshakes fire at the edge.
  task automatic tick();
    if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    if (in_valid && in_ready) exp_q.push_back(model_entry(in_funct, in_shamt, in_rs, in_rt, in_rd));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    clrn = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (observed() !== 39'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", observed()); end
    clrn = 1'b1;
  endtask

  task automatic test_sll();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_funct = 6'd0; in_shamt = 5'd31; in_rt = 32'h0000_0001; in_rd = 5'd3; in_rs = $urandom;
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sll_in_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sll_latency: got %b expected 1", out_valid); end
    n_checks++;
    if (observed() !== {32'h8000_0000, 5'd3, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL sll_entry: got %h expected %h", observed(), {32'h8000_0000, 5'd3, 1'b1, 1'b0});
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sll_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_variable();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_funct = 6'd7; in_rt = 32'h8000_00F0; in_rs = 32'hFFFF_FFE4; in_rd = 5'd5; in_shamt = 5'($urandom);
    tick();
    in_funct = 6'd6;
    n_checks++;
    if (out_result !== 32'hF800_000F) begin n_fail++; $display("FAIL srav_result: got %h expected f800000f", out_result); end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_result !== 32'h0800_000F) begin n_fail++; $display("FAIL srlv_result: got %h expected 0800000f", out_result); end
    tick();
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_funct = 6'b100000; in_rt = 32'h1234_5678; in_rd = 5'd7; in_shamt = 5'd5; in_rs = 32'd9;
    tick();
    in_funct = 6'd3; in_rt = 32'h8000_0000; in_shamt = 5'd4; in_rd = 5'd0;
    n_checks++;
    if (observed() !== {32'h1234_5678, 5'd7, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL illegal_entry: got %h expected %h", observed(), {32'h1234_5678, 5'd7, 1'b0, 1'b1});
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (observed() !== {32'hF800_0000, 5'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL sra_rd0_entry: got %h expected %h", observed(), {32'hF800_0000, 5'd0, 1'b0, 1'b0});
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit accepted;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      rand_op(1'b1);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept_%0d: got %b expected 1", i, in_ready); end
      tick();
    end
    rand_op(1'b0);
    repeat (2) begin
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_stall: got %b expected 0", in_ready); end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || exp_q.size() == 0 || observed() !== exp_q[0]) begin
        n_fail++; $display("FAIL bp_drain_%0d: got v=%b %h expected %h", i, out_valid, observed(),
                           (exp_q.size() > 0) ? exp_q[0] : 39'd0);
      end
      accepted = in_valid && in_ready;
      tick();
      if (accepted) in_valid = 1'b0;
    end
    n_checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0 || in_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_no_loss: got v=%b left=%0d pending=%b expected empty", out_valid, exp_q.size(), in_valid);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin in_valid = 1'b1; rand_op(1'b0); end
      else in_valid = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready_%0d: got %b expected 1", k, in_ready); end
      if (k > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || exp_q.size() != 1 || observed() !== exp_q[0]) begin
          n_fail++; $display("FAIL stream_out_%0d: got v=%b %h expected %h", k, out_valid, observed(),
                             (exp_q.size() > 0) ? exp_q[0] : 39'd0);
        end
      end
      tick();
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (2) begin rand_op(1'b1); tick(); end
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rmid_full: got %b expected 0", in_ready); end
    clrn = 1'b0;
    @(posedge clk);
    #1;
    clrn = 1'b1;
    exp_q.delete();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || observed() !== 39'd0) begin
      n_fail++; $display("FAIL rmid_cleared: got v=%b r=%b %h expected v=0 r=1 0", out_valid, in_ready, observed());
    end
    out_ready = 1'b1;
    repeat (3) begin
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale: got %b expected 0", out_valid); end
      tick();
    end
    in_valid = 1'b1;
    rand_op(1'b0);
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || exp_q.size() != 1 || observed() !== exp_q[0]) begin
      n_fail++; $display("FAIL rmid_first_accept: got v=%b %h expected %h", out_valid, observed(),
                         (exp_q.size() > 0) ? exp_q[0] : 39'd0);
    end
    tick();
  endtask

  task automatic test_random();
    bit hold;
    do_reset();
    hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_op(1'b0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      n_checks++;
      if (in_ready !== (exp_q.size() != DEPTH) || out_valid !== (exp_q.size() != 0)) begin
        n_fail++; $display("FAIL rand_flags_%0d: got r=%b v=%b expected occupancy %0d", c, in_ready, out_valid, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        n_checks++;
        if (observed() !== exp_q[0]) begin
          n_fail++; $display("FAIL rand_head_%0d: got %h expected %h", c, observed(), exp_q[0]);
        end
      end
      hold = in_valid && !in_ready;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      n_checks++;
      if (observed() !== exp_q[0]) begin n_fail++; $display("FAIL rand_drain: got %h expected %h", observed(), exp_q[0]); end
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rand_drain_done: got v=%b left=%0d expected empty", out_valid, exp_q.size());
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    clrn = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_funct = '0;
    in_shamt = '0;
    in_rs = '0;
    in_rt = '0;
    in_rd = '0;
    test_reset();
    test_sll();
    test_variable();
    test_illegal();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
